// File: rtl/regfile_pkg.sv
// Shared FunSel encodings and the per-register next-value function for the
// parametrised register file.
package regfile_pkg;

  // Widest register the next-value function supports.
  localparam int MAX_W = 64;

  localparam logic [2:0] FS_DEC       = 3'b000;
  localparam logic [2:0] FS_INC       = 3'b001;
  localparam logic [2:0] FS_LOAD      = 3'b010;
  localparam logic [2:0] FS_CLR       = 3'b011;
  localparam logic [2:0] FS_LOADL_CLR = 3'b100;
  localparam logic [2:0] FS_LOADL     = 3'b101;
  localparam logic [2:0] FS_LOADH     = 3'b110;
  localparam logic [2:0] FS_SEXT      = 3'b111;

  // Operates on MAX_W-bit containers; bits above width are kept zero.
  function automatic logic [MAX_W-1:0] next_value(
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] i,
    input logic [2:0]       funsel,
    input logic             sat,
    input int               width
  );
    logic [MAX_W-1:0] ones;
    logic [MAX_W-1:0] lo_mask;
    logic [MAX_W-1:0] il;
    logic             sign;
    int               half;
    half    = width / 2;
    ones    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    lo_mask = (MAX_W'(1) << half) - MAX_W'(1);
    il      = i & lo_mask;
    sign    = il[half-1];
    next_value = q;
    case (funsel)
      FS_DEC:       next_value = (sat && q == '0) ? q : ((q - MAX_W'(1)) & ones);
      FS_INC:       next_value = (sat && q == ones) ? q : ((q + MAX_W'(1)) & ones);
      FS_LOAD:      next_value = i & ones;
      FS_CLR:       next_value = '0;
      FS_LOADL_CLR: next_value = il;
      FS_LOADL:     next_value = (q & ~lo_mask & ones) | il;
      FS_LOADH:     next_value = ((il << half) & ones) | (q & lo_mask);
      FS_SEXT:      next_value = sign ? ((ones & ~lo_mask) | il) : il;
      default:      next_value = q;
    endcase
  endfunction

endpackage

// File: rtl/gen_register.sv
// One register of the file: applies FunSel when enabled and exposes its
// next-state value so the read ports can forward a same-edge write.
module gen_register
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nextQ
);

  // NOTE: default assigned first so this block can never infer a latch.
  always_comb begin
    nextQ = Q;
    if (Reset) begin
      nextQ = '0;
    end else if (E) begin
      nextQ = WIDTH'(next_value(MAX_W'(Q), MAX_W'(I), FunSel, SAT, WIDTH));
    end
  end

  // NOTE: non-blocking so every register in the file samples pre-edge values together.
  always_ff @(posedge Clock) begin
    if (Reset) Q <= '0;
    else       Q <= nextQ;
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised GP + scratch register file with two read ports, optional
// registered outputs (with write forwarding) and per-port zero flags.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_GP  = 4,
  parameter int NUM_SCR = 4,
  parameter bit SAT     = 1'b0,
  parameter bit REG_OUT = 1'b0,
  localparam int NUM_REGS = NUM_GP + NUM_SCR,
  localparam int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SCRW     = (NUM_SCR > 0) ? NUM_SCR : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  I,
  input  logic [2:0]        FunSel,
  input  logic [NUM_GP-1:0] RegSel,
  input  logic [SCRW-1:0]   ScrSel,
  input  logic [SELW-1:0]   OutASel,
  input  logic [SELW-1:0]   OutBSel,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic              OutAZero,
  output logic              OutBZero
);

  logic [NUM_REGS-1:0][WIDTH-1:0] q_arr;
  logic [NUM_REGS-1:0][WIDTH-1:0] n_arr;
  logic [NUM_REGS-1:0]            en;
  logic [WIDTH-1:0]               a_src;
  logic [WIDTH-1:0]               b_src;

  // Select vectors are active-low with the first register in the MSB.
  for (genvar g = 0; g < NUM_GP; g++) begin : g_gp_en
    assign en[g] = ~RegSel[NUM_GP-1-g];
  end

  if (NUM_SCR > 0) begin : g_scr_en
    for (genvar s = 0; s < NUM_SCR; s++) begin : g_s
      assign en[NUM_GP+s] = ~ScrSel[NUM_SCR-1-s];
    end
  end else begin : g_no_scr
    logic unused_scr;
    assign unused_scr = ^ScrSel;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    gen_register #(.WIDTH(WIDTH), .SAT(SAT)) u_reg (
      .Clock (Clock),
      .Reset (Reset),
      .E     (en[r]),
      .FunSel(FunSel),
      .I     (I),
      .Q     (q_arr[r]),
      .nextQ (n_arr[r])
    );
  end

  function automatic logic [WIDTH-1:0] read_sel(
    input logic [NUM_REGS-1:0][WIDTH-1:0] arr,
    input logic [SELW-1:0]                sel
  );
    read_sel = '0;
    if (int'(sel) < NUM_REGS) read_sel = arr[sel];
  endfunction

  // Registered ports read the post-write value, so a write is visible right after its edge.
  assign a_src = read_sel(REG_OUT ? n_arr : q_arr, OutASel);
  assign b_src = read_sel(REG_OUT ? n_arr : q_arr, OutBSel);

  if (REG_OUT) begin : g_reg_out
    always_ff @(posedge Clock) begin
      if (Reset) begin
        OutA     <= '0;
        OutB     <= '0;
        OutAZero <= 1'b1;
        OutBZero <= 1'b1;
      end else begin
        OutA     <= a_src;
        OutB     <= b_src;
        OutAZero <= (a_src == '0);
        OutBZero <= (b_src == '0);
      end
    end
  end else begin : g_comb_out
    assign OutA     = a_src;
    assign OutB     = b_src;
    assign OutAZero = (a_src == '0);
    assign OutBZero = (b_src == '0);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default, saturating, registered-output
// and a small 8-bit 3+2 configuration side by side.
module tb_register_file_param;
  import regfile_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Shared stimulus for the three 16-bit 4+4 instances.
  logic        rst;
  logic [15:0] i_d;
  logic [2:0]  fs;
  logic [3:0]  rsel, ssel;
  logic [2:0]  asel, bsel;
  logic [15:0] oa0, ob0, oa1, ob1, oa2, ob2;
  logic        za0, zb0, za1, zb1, za2, zb2;

  // Small instance: WIDTH=8, NUM_GP=3, NUM_SCR=2.
  logic       s_rst;
  logic [7:0] s_i;
  logic [2:0] s_fs;
  logic [2:0] s_rsel;
  logic [1:0] s_ssel;
  logic [2:0] s_asel, s_bsel;
  logic [7:0] s_oa, s_ob;
  logic       s_za, s_zb;

  register_file_param dut_def (
    .Clock(Clock), .Reset(rst), .I(i_d), .FunSel(fs), .RegSel(rsel), .ScrSel(ssel),
    .OutASel(asel), .OutBSel(bsel), .OutA(oa0), .OutB(ob0), .OutAZero(za0), .OutBZero(zb0)
  );

  register_file_param #(.SAT(1'b1)) dut_sat (
    .Clock(Clock), .Reset(rst), .I(i_d), .FunSel(fs), .RegSel(rsel), .ScrSel(ssel),
    .OutASel(asel), .OutBSel(bsel), .OutA(oa1), .OutB(ob1), .OutAZero(za1), .OutBZero(zb1)
  );

  register_file_param #(.REG_OUT(1'b1)) dut_reg (
    .Clock(Clock), .Reset(rst), .I(i_d), .FunSel(fs), .RegSel(rsel), .ScrSel(ssel),
    .OutASel(asel), .OutBSel(bsel), .OutA(oa2), .OutB(ob2), .OutAZero(za2), .OutBZero(zb2)
  );

  register_file_param #(.WIDTH(8), .NUM_GP(3), .NUM_SCR(2)) dut_small (
    .Clock(Clock), .Reset(s_rst), .I(s_i), .FunSel(s_fs), .RegSel(s_rsel), .ScrSel(s_ssel),
    .OutASel(s_asel), .OutBSel(s_bsel), .OutA(s_oa), .OutB(s_ob), .OutAZero(s_za), .OutBZero(s_zb)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // ea/eb: expected reads after the edge with SAT=0; ea_s/eb_s: with SAT=1.
  typedef struct {
    logic        rst;
    logic [2:0]  fs;
    logic [3:0]  rsel;
    logic [3:0]  ssel;
    logic [15:0] i;
    logic [2:0]  asel;
    logic [2:0]  bsel;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ea_s;
    logic [15:0] eb_s;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, FS_LOAD,      4'b0110, 4'b1111, 16'hBEEF, 3'd0, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[1]  = '{1'b0, FS_LOAD,      4'b1011, 4'b1111, 16'hFFFF, 3'd1, 3'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[2]  = '{1'b0, FS_INC,       4'b1011, 4'b1111, 16'h0000, 3'd1, 3'd0, 16'h0000, 16'hBEEF, 16'hFFFF, 16'hBEEF};
    vecs[3]  = '{1'b0, FS_DEC,       4'b1101, 4'b1111, 16'h0000, 3'd2, 3'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[4]  = '{1'b0, FS_LOAD,      4'b1111, 4'b0111, 16'h1234, 3'd4, 3'd4, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    vecs[5]  = '{1'b0, FS_SEXT,      4'b1111, 4'b0111, 16'h0080, 3'd4, 3'd0, 16'hFF80, 16'hBEEF, 16'hFF80, 16'hBEEF};
    vecs[6]  = '{1'b0, FS_LOADH,     4'b1111, 4'b0111, 16'hCDAB, 3'd4, 3'd5, 16'hAB80, 16'h0000, 16'hAB80, 16'h0000};
    vecs[7]  = '{1'b0, FS_LOADL,     4'b1111, 4'b0111, 16'h7711, 3'd4, 3'd5, 16'hAB11, 16'h0000, 16'hAB11, 16'h0000};
    vecs[8]  = '{1'b0, FS_LOADL_CLR, 4'b1111, 4'b1011, 16'h12C3, 3'd5, 3'd4, 16'h00C3, 16'hAB11, 16'h00C3, 16'hAB11};
    vecs[9]  = '{1'b0, FS_SEXT,      4'b1111, 4'b1011, 16'h0042, 3'd5, 3'd4, 16'h0042, 16'hAB11, 16'h0042, 16'hAB11};
    vecs[10] = '{1'b0, FS_CLR,       4'b0110, 4'b1111, 16'hFFFF, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[11] = '{1'b0, FS_INC,       4'b1111, 4'b0000, 16'h0000, 3'd6, 3'd7, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vecs[12] = '{1'b0, FS_CLR,       4'b1111, 4'b1111, 16'h0000, 3'd4, 3'd5, 16'hAB12, 16'h0043, 16'hAB12, 16'h0043};
    vecs[13] = '{1'b0, FS_DEC,       4'b1011, 4'b1111, 16'h0000, 3'd1, 3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0000};

    rst = 1'b1; fs = FS_CLR; rsel = '1; ssel = '1; i_d = '0; asel = '0; bsel = '0;
    s_rst = 1'b1; s_fs = FS_CLR; s_rsel = '1; s_ssel = '1; s_i = '0; s_asel = '0; s_bsel = '0;
    tick();

    // Load every register, then reset while a different load is requested.
    rst = 1'b0; s_rst = 1'b0; fs = FS_LOAD; rsel = '0; ssel = '0; i_d = 16'hA5C3;
    tick();
    check("load_all", oa0, 16'hA5C3);
    rst = 1'b1; i_d = 16'h1111;
    tick();
    check("rst_reg_out_a", oa2, 16'h0000);
    check("rst_reg_out_za", za2, 1'b1);
    check("rst_reg_out_zb", zb2, 1'b1);
    rst = 1'b0; rsel = '1; ssel = '1;
    for (int r = 0; r < 8; r++) begin
      asel = r[2:0];
      bsel = 3'(7 - r);
      #1;
      check($sformatf("rst_r%0d_a", r), oa0, 16'h0000);
      check($sformatf("rst_r%0d_b", r), ob0, 16'h0000);
      check($sformatf("rst_r%0d_za", r), za0, 1'b1);
      check($sformatf("rst_r%0d_zb", r), zb0, 1'b1);
    end

    for (int k = 0; k < 14; k++) begin
      rst = vecs[k].rst; fs = vecs[k].fs; rsel = vecs[k].rsel; ssel = vecs[k].ssel;
      i_d = vecs[k].i; asel = vecs[k].asel; bsel = vecs[k].bsel;
      tick();
      check($sformatf("v%0d_def_a", k), oa0, vecs[k].ea);
      check($sformatf("v%0d_def_b", k), ob0, vecs[k].eb);
      check($sformatf("v%0d_def_za", k), za0, vecs[k].ea == 16'h0);
      check($sformatf("v%0d_def_zb", k), zb0, vecs[k].eb == 16'h0);
      check($sformatf("v%0d_sat_a", k), oa1, vecs[k].ea_s);
      check($sformatf("v%0d_sat_b", k), ob1, vecs[k].eb_s);
      check($sformatf("v%0d_sat_za", k), za1, vecs[k].ea_s == 16'h0);
      check($sformatf("v%0d_reg_a", k), oa2, vecs[k].ea);
      check($sformatf("v%0d_reg_b", k), ob2, vecs[k].eb);
      check($sformatf("v%0d_reg_zb", k), zb2, vecs[k].eb == 16'h0);
    end

    // Forwarding: write S1 while reading it on port A.
    rsel = '1; ssel = 4'b0111; fs = FS_LOAD; i_d = 16'h5A5A; asel = 3'd4; bsel = 3'd4;
    #1;
    check("fwd_comb_pre", oa0, 16'hAB12);
    check("fwd_reg_pre", oa2, 16'hFFFF);
    tick();
    check("fwd_reg_post", oa2, 16'h5A5A);
    check("fwd_reg_post_b", ob2, 16'h5A5A);
    check("fwd_comb_post", oa0, 16'h5A5A);

    // Small configuration: out-of-range selects, WIDTH=8 byte ops, wrap, reset priority.
    s_fs = FS_LOAD; s_rsel = '0; s_ssel = '0; s_i = 8'h7E; s_asel = 3'd0; s_bsel = 3'd7;
    tick();
    check("sm_load_a", s_oa, 8'h7E);
    check("sm_load_za", s_za, 1'b0);
    check("sm_oor7_b", s_ob, 8'h00);
    check("sm_oor7_zb", s_zb, 1'b1);
    s_rsel = '1; s_ssel = '1; s_bsel = 3'd5;
    #1;
    check("sm_oor5_b", s_ob, 8'h00);
    check("sm_oor5_zb", s_zb, 1'b1);
    s_bsel = 3'd4;
    #1;
    check("sm_s2_b", s_ob, 8'h7E);
    s_ssel = 2'b01; s_fs = FS_SEXT; s_i = 8'h38; s_asel = 3'd3;
    tick();
    check("sm_sext_s1", s_oa, 8'hF8);
    check("sm_sext_s2_kept", s_ob, 8'h7E);
    s_ssel = 2'b11; s_rsel = 3'b011; s_fs = FS_LOAD; s_i = 8'hFF; s_asel = 3'd0;
    tick();
    s_fs = FS_INC;
    tick();
    check("sm_inc_wrap", s_oa, 8'h00);
    check("sm_inc_wrap_z", s_za, 1'b1);
    s_rsel = '0; s_ssel = '0; s_fs = FS_LOAD; s_i = 8'h33;
    tick();
    check("sm_load33", s_oa, 8'h33);
    s_fs = FS_CLR; s_rst = 1'b1;
    tick();
    s_rsel = '0; s_fs = FS_LOAD; s_i = 8'h55;
    tick();
    check("sm_rst_beats_load_a", s_oa, 8'h00);
    check("sm_rst_beats_load_za", s_za, 1'b1);
    s_bsel = 3'd3;
    #1;
    check("sm_rst_s1", s_ob, 8'h00);
    s_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
